// File: rtl/i2c_xfer_sequencer_if.sv
// i2c_xfer_sequencer_if: bundles the configuration, TX/RX FIFO, I2C core
// command and status signals of i2c_xfer_sequencer.
// master: the sequencer side; slave: the surrounding FIFOs, core and host.
interface i2c_xfer_sequencer_if;
    logic [13:0] CFG;
    logic [13:0] TIMEOUT;
    logic        TX_EMPTY;
    logic [31:0] TX_DATA;
    logic        TX_RD_EN;
    logic        RX_FULL;
    logic        RX_WR_EN;
    logic [31:0] RX_WDATA;
    logic [2:0]  CORE_CMD;
    logic        CORE_CMD_VALID;
    logic [7:0]  CORE_WDATA;
    logic        CORE_READY;
    logic        CORE_DONE;
    logic        CORE_ACK;
    logic [7:0]  CORE_RDATA;
    logic        BUSY;
    logic        XFER_DONE;
    logic        ERROR;
    logic [1:0]  ERR_CODE;

    modport master (
        input  CFG, TIMEOUT, TX_EMPTY, TX_DATA, RX_FULL,
               CORE_READY, CORE_DONE, CORE_ACK, CORE_RDATA,
        output TX_RD_EN, RX_WR_EN, RX_WDATA, CORE_CMD, CORE_CMD_VALID,
               CORE_WDATA, BUSY, XFER_DONE, ERROR, ERR_CODE
    );

    modport slave (
        output CFG, TIMEOUT, TX_EMPTY, TX_DATA, RX_FULL,
               CORE_READY, CORE_DONE, CORE_ACK, CORE_RDATA,
        input  TX_RD_EN, RX_WR_EN, RX_WDATA, CORE_CMD, CORE_CMD_VALID,
               CORE_WDATA, BUSY, XFER_DONE, ERROR, ERR_CODE
    );
endinterface

// File: rtl/i2c_xfer_sequencer.sv
// i2c_xfer_sequencer: turns a GO request into the I2C core command stream
// START, address WRITE, N data bytes (WRITE from the TX FIFO or READ into
// the RX FIFO), STOP, with NACK error reporting.
// Build option: define I2C_SEQ_TIMEOUT_EN to enable the per-state wait
// timeout (ERR_CODE=3); without it TIMEOUT is ignored.
module i2c_xfer_sequencer (
    input logic                   PCLK,
    input logic                   PRESET,
    i2c_xfer_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_WAIT, S_FETCH, S_PUSH, S_STOP, S_STOPW
    } state_t;

    typedef enum logic [1:0] {PH_START, PH_ADDR, PH_DATA} phase_t;

    typedef enum logic [2:0] {
        C_START     = 3'd0,
        C_WRITE     = 3'd1,
        C_READ_ACK  = 3'd2,
        C_READ_NACK = 3'd3,
        C_STOP      = 3'd4
    } cmd_t;

    state_t      state;
    phase_t      phase;
    cmd_t        cmd;
    logic        cmd_valid;
    logic [7:0]  wdata;
    logic        rw;
    logic [6:0]  addr;
    logic [4:0]  last_idx;
    logic [4:0]  byte_idx;
    logic        go_q;
    logic        go_armed;
    logic        go_edge;
    logic        tx_rd_en;
    logic        rx_wr_en;
    logic [31:0] rx_wdata;
    logic [1:0]  err_code;
    logic        xfer_done;
    logic        timeout_hit;
    logic        unused_tx_hi;

    // go_armed blocks a GO level held through reset from looking like an edge
    assign go_edge      = bus.CFG[0] & ~go_q & go_armed;
    assign unused_tx_hi = ^bus.TX_DATA[31:8];

`ifdef I2C_SEQ_TIMEOUT_EN
    state_t      state_prev;
    logic [13:0] tcnt;
    logic [13:0] tcnt_cur;
    logic        counting;

    // Cycles spent in the current state; restarts at zero on every state change
    always_comb begin
        tcnt_cur    = (state != state_prev) ? '0 : tcnt;
        counting    = (state == S_CMD) || (state == S_WAIT) || (state == S_FETCH) ||
                      (state == S_PUSH) || (state == S_STOPW);
        timeout_hit = counting && (bus.TIMEOUT != '0) &&
                      (({1'b0, tcnt_cur} + 15'd1) == {1'b0, bus.TIMEOUT});
    end

    // Timeout counter and previous-state register
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_prev <= S_IDLE;
            tcnt       <= '0;
        end else begin
            state_prev <= state;
            tcnt       <= counting ? tcnt_cur + 14'd1 : '0;
        end
    end
`else
    logic unused_timeout;
    assign timeout_hit    = 1'b0;
    assign unused_timeout = ^bus.TIMEOUT;
`endif

    // Transaction sequencer: command issue, FIFO handshakes and error tracking
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= S_IDLE;
            phase     <= PH_START;
            cmd       <= C_START;
            cmd_valid <= 1'b0;
            wdata     <= '0;
            rw        <= 1'b0;
            addr      <= '0;
            last_idx  <= '0;
            byte_idx  <= '0;
            go_q      <= 1'b0;
            go_armed  <= 1'b0;
            tx_rd_en  <= 1'b0;
            rx_wr_en  <= 1'b0;
            rx_wdata  <= '0;
            err_code  <= '0;
            xfer_done <= 1'b0;
        end else begin
            go_q      <= bus.CFG[0];
            go_armed  <= go_armed | ~bus.CFG[0];
            tx_rd_en  <= 1'b0;
            rx_wr_en  <= 1'b0;
            xfer_done <= 1'b0;
            if (timeout_hit) begin
                err_code <= 2'd3;
                if (state == S_STOPW) begin
                    cmd_valid <= 1'b0;
                    xfer_done <= 1'b1;
                    state     <= S_IDLE;
                end else begin
                    cmd       <= C_STOP;
                    cmd_valid <= 1'b1;
                    state     <= S_STOP;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (go_edge) begin
                            rw        <= bus.CFG[1];
                            addr      <= bus.CFG[8:2];
                            last_idx  <= bus.CFG[13:9];
                            byte_idx  <= '0;
                            err_code  <= '0;
                            phase     <= PH_START;
                            cmd       <= C_START;
                            cmd_valid <= 1'b1;
                            state     <= S_CMD;
                        end
                    end
                    S_CMD: begin
                        if (bus.CORE_READY) begin
                            cmd_valid <= 1'b0;
                            state     <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (bus.CORE_DONE) begin
                            case (phase)
                                PH_START: begin
                                    cmd       <= C_WRITE;
                                    wdata     <= {addr, rw};
                                    cmd_valid <= 1'b1;
                                    phase     <= PH_ADDR;
                                    state     <= S_CMD;
                                end
                                PH_ADDR: begin
                                    phase <= PH_DATA;
                                    if (!bus.CORE_ACK) begin
                                        err_code  <= 2'd1;
                                        cmd       <= C_STOP;
                                        cmd_valid <= 1'b1;
                                        state     <= S_STOP;
                                    end else if (!rw) begin
                                        state <= S_FETCH;
                                    end else begin
                                        cmd       <= (last_idx == '0) ? C_READ_NACK : C_READ_ACK;
                                        cmd_valid <= 1'b1;
                                        state     <= S_CMD;
                                    end
                                end
                                default: begin
                                    if (rw) begin
                                        rx_wdata <= {24'd0, bus.CORE_RDATA};
                                        state    <= S_PUSH;
                                    end else if (!bus.CORE_ACK || (byte_idx == last_idx)) begin
                                        if (!bus.CORE_ACK) begin
                                            err_code <= 2'd2;
                                        end
                                        cmd       <= C_STOP;
                                        cmd_valid <= 1'b1;
                                        state     <= S_STOP;
                                    end else begin
                                        byte_idx <= byte_idx + 5'd1;
                                        state    <= S_FETCH;
                                    end
                                end
                            endcase
                        end
                    end
                    S_FETCH: begin
                        if (!bus.TX_EMPTY) begin
                            tx_rd_en  <= 1'b1;
                            wdata     <= bus.TX_DATA[7:0];
                            cmd       <= C_WRITE;
                            cmd_valid <= 1'b1;
                            state     <= S_CMD;
                        end
                    end
                    S_PUSH: begin
                        if (!bus.RX_FULL) begin
                            rx_wr_en <= 1'b1;
                            if (byte_idx == last_idx) begin
                                cmd       <= C_STOP;
                                cmd_valid <= 1'b1;
                                state     <= S_STOP;
                            end else begin
                                byte_idx  <= byte_idx + 5'd1;
                                cmd       <= ((byte_idx + 5'd1) == last_idx) ? C_READ_NACK : C_READ_ACK;
                                cmd_valid <= 1'b1;
                                state     <= S_CMD;
                            end
                        end
                    end
                    S_STOP: begin
                        if (bus.CORE_READY) begin
                            cmd_valid <= 1'b0;
                            state     <= S_STOPW;
                        end
                    end
                    S_STOPW: begin
                        if (bus.CORE_DONE) begin
                            xfer_done <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.CORE_CMD       = cmd;
    assign bus.CORE_CMD_VALID = cmd_valid;
    assign bus.CORE_WDATA     = wdata;
    assign bus.TX_RD_EN       = tx_rd_en;
    assign bus.RX_WR_EN       = rx_wr_en;
    assign bus.RX_WDATA       = rx_wdata;
    assign bus.BUSY           = (state != S_IDLE);
    assign bus.XFER_DONE      = xfer_done;
    assign bus.ERR_CODE       = err_code;
    assign bus.ERROR          = (err_code != 2'd0);

endmodule

// File: tb/tb_i2c_xfer_sequencer.sv
// tb_i2c_xfer_sequencer: directed self-checking bench for i2c_xfer_sequencer
// covering reset, write, read with RX backpressure, NACK errors, GO edge
// handling, reset mid-transaction and (with I2C_SEQ_TIMEOUT_EN) the timeout.
module tb_i2c_xfer_sequencer;

    logic PCLK = 1'b0;
    logic PRESET;
    int   vectors = 0;
    int   errors  = 0;

    logic [7:0] tx_mem [0:7];
    int         tx_count = 0;
    int         tx_idx   = 0;

    i2c_xfer_sequencer_if bus ();

    i2c_xfer_sequencer dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    always #5 PCLK = ~PCLK;

    // First-word-fall-through TX FIFO model: advances on each TX_RD_EN pulse
    always @(posedge PCLK) begin
        if (bus.TX_RD_EN) tx_idx <= tx_idx + 1;
    end

    assign bus.TX_EMPTY = (tx_idx >= tx_count);
    assign bus.TX_DATA  = {24'h0, tx_mem[tx_idx[2:0]]};

    // Hard stop in case something unbounded slips through
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " BUSY"}, bus.BUSY, 0);
        chk({tag, " CMD_VALID"}, bus.CORE_CMD_VALID, 0);
        chk({tag, " CMD"}, bus.CORE_CMD, 0);
        chk({tag, " WDATA"}, bus.CORE_WDATA, 0);
        chk({tag, " TX_RD_EN"}, bus.TX_RD_EN, 0);
        chk({tag, " RX_WR_EN"}, bus.RX_WR_EN, 0);
        chk({tag, " RX_WDATA"}, bus.RX_WDATA, 0);
        chk({tag, " XFER_DONE"}, bus.XFER_DONE, 0);
        chk({tag, " ERROR"}, bus.ERROR, 0);
        chk({tag, " ERR_CODE"}, bus.ERR_CODE, 0);
    endtask

    // Core model: wait for a command, check it stays stable while not ready,
    // accept it, then complete it one cycle later with the given ACK/data
    task automatic serve(input string tag, input logic [2:0] ecmd, input logic chkw,
                         input logic [7:0] ewd, input logic ack, input logic [7:0] rd);
        int n = 0;
        while (bus.CORE_CMD_VALID !== 1'b1 && n < 60) begin
            @(negedge PCLK);
            n++;
        end
        chk({tag, " valid"}, bus.CORE_CMD_VALID, 1);
        chk({tag, " cmd"}, bus.CORE_CMD, ecmd);
        if (chkw) chk({tag, " wdata"}, bus.CORE_WDATA, ewd);
        @(negedge PCLK);
        chk({tag, " held cmd"}, bus.CORE_CMD, ecmd);
        bus.CORE_READY = 1'b1;
        @(negedge PCLK);
        bus.CORE_READY = 1'b0;
        bus.CORE_DONE  = 1'b1;
        bus.CORE_ACK   = ack;
        bus.CORE_RDATA = rd;
        @(negedge PCLK);
        bus.CORE_DONE  = 1'b0;
        bus.CORE_ACK   = 1'b0;
    endtask

    initial begin
        PRESET         = 1'b1;
        bus.CFG        = '0;
        bus.TIMEOUT    = '0;
        bus.RX_FULL    = 1'b0;
        bus.CORE_READY = 1'b0;
        bus.CORE_DONE  = 1'b0;
        bus.CORE_ACK   = 1'b0;
        bus.CORE_RDATA = '0;
        for (int i = 0; i < 8; i++) tx_mem[i] = '0;
        repeat (2) @(negedge PCLK);
        chk_idle("reset");
        PRESET = 1'b0;
        @(negedge PCLK);

        // Write: addr 0x50, 2 bytes A1, B2
        tx_mem[0] = 8'hA1;
        tx_mem[1] = 8'hB2;
        tx_count  = 2;
        bus.CFG   = {5'd1, 7'h50, 1'b0, 1'b1};
        @(negedge PCLK);
        chk("wr go->start valid", bus.CORE_CMD_VALID, 1);
        chk("wr busy", bus.BUSY, 1);
        serve("wr start", 3'd0, 1'b0, 8'h00, 1'b1, 8'h00);
        bus.CFG[8:2] = 7'h12;
        serve("wr addr", 3'd1, 1'b1, 8'hA0, 1'b1, 8'h00);
        serve("wr d0", 3'd1, 1'b1, 8'hA1, 1'b1, 8'h00);
        serve("wr d1", 3'd1, 1'b1, 8'hB2, 1'b1, 8'h00);
        serve("wr stop", 3'd4, 1'b0, 8'h00, 1'b1, 8'h00);
        chk("wr xfer_done", bus.XFER_DONE, 1);
        chk("wr busy end", bus.BUSY, 0);
        chk("wr error", bus.ERROR, 0);
        chk("wr tx pops", tx_idx, 2);
        @(negedge PCLK);
        chk("wr xfer_done pulse", bus.XFER_DONE, 0);

        // Read: addr 0x50, 3 bytes, RX_FULL backpressure on byte 1
        bus.CFG[0] = 1'b0;
        @(negedge PCLK);
        bus.CFG = {5'd2, 7'h50, 1'b1, 1'b1};
        @(negedge PCLK);
        serve("rd start", 3'd0, 1'b0, 8'h00, 1'b1, 8'h00);
        serve("rd addr", 3'd1, 1'b1, 8'hA1, 1'b1, 8'h00);
        serve("rd b0", 3'd2, 1'b0, 8'h00, 1'b1, 8'h11);
        chk("rd b0 data", bus.RX_WDATA, 32'h11);
        chk("rd b0 no early push", bus.RX_WR_EN, 0);
        @(negedge PCLK);
        chk("rd b0 push", bus.RX_WR_EN, 1);
        bus.RX_FULL = 1'b1;
        serve("rd b1", 3'd2, 1'b0, 8'h00, 1'b0, 8'h22);
        chk("rd b1 data", bus.RX_WDATA, 32'h22);
        for (int i = 0; i < 5; i++) begin
            chk("rd b1 held push", bus.RX_WR_EN, 0);
            if (i == 1) bus.CFG[0] = 1'b0;
            if (i == 2) bus.CFG[0] = 1'b1;
            @(negedge PCLK);
        end
        chk("rd b1 held push last", bus.RX_WR_EN, 0);
        chk("rd busy during push", bus.BUSY, 1);
        bus.RX_FULL = 1'b0;
        @(negedge PCLK);
        chk("rd b1 push", bus.RX_WR_EN, 1);
        serve("rd b2", 3'd3, 1'b0, 8'h00, 1'b1, 8'h33);
        chk("rd b2 data", bus.RX_WDATA, 32'h33);
        @(negedge PCLK);
        chk("rd b2 push", bus.RX_WR_EN, 1);
        serve("rd stop", 3'd4, 1'b0, 8'h00, 1'b1, 8'h00);
        chk("rd xfer_done", bus.XFER_DONE, 1);
        chk("rd error", bus.ERROR, 0);
        repeat (3) @(negedge PCLK);
        chk("go while busy ignored", bus.BUSY, 0);
        chk("go while busy no cmd", bus.CORE_CMD_VALID, 0);

        // Address NACK
        bus.CFG[0] = 1'b0;
        tx_mem[2]  = 8'h5A;
        tx_count   = 3;
        @(negedge PCLK);
        bus.CFG = {5'd0, 7'h3C, 1'b0, 1'b1};
        @(negedge PCLK);
        serve("an start", 3'd0, 1'b0, 8'h00, 1'b1, 8'h00);
        serve("an addr", 3'd1, 1'b1, 8'h78, 1'b0, 8'h00);
        chk("an err_code", bus.ERR_CODE, 1);
        chk("an error", bus.ERROR, 1);
        serve("an stop", 3'd4, 1'b0, 8'h00, 1'b1, 8'h00);
        chk("an xfer_done", bus.XFER_DONE, 1);
        chk("an no tx pop", tx_idx, 2);
        chk("an error sticky", bus.ERR_CODE, 1);

        // CORE_DONE while idle is ignored
        bus.CORE_DONE = 1'b1;
        @(negedge PCLK);
        bus.CORE_DONE = 1'b0;
        chk("idle done busy", bus.BUSY, 0);
        chk("idle done xfer_done", bus.XFER_DONE, 0);

        // Write data NACK; accepted GO clears the previous error
        bus.CFG[0] = 1'b0;
        @(negedge PCLK);
        bus.CFG = {5'd1, 7'h50, 1'b0, 1'b1};
        @(negedge PCLK);
        chk("dn error cleared", bus.ERR_CODE, 0);
        serve("dn start", 3'd0, 1'b0, 8'h00, 1'b1, 8'h00);
        serve("dn addr", 3'd1, 1'b1, 8'hA0, 1'b1, 8'h00);
        serve("dn d0", 3'd1, 1'b1, 8'h5A, 1'b0, 8'h00);
        chk("dn err_code", bus.ERR_CODE, 2);
        serve("dn stop", 3'd4, 1'b0, 8'h00, 1'b1, 8'h00);
        chk("dn xfer_done", bus.XFER_DONE, 1);
        chk("dn tx pops", tx_idx, 3);

        // Reset during WAIT with GO held high
        bus.CFG[0] = 1'b0;
        @(negedge PCLK);
        bus.CFG[0] = 1'b1;
        @(negedge PCLK);
        chk("rst start valid", bus.CORE_CMD_VALID, 1);
        bus.CORE_READY = 1'b1;
        @(negedge PCLK);
        bus.CORE_READY = 1'b0;
        chk("rst in wait", bus.BUSY, 1);
        PRESET = 1'b1;
        @(negedge PCLK);
        chk_idle("rst mid");
        PRESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            chk("rst go held busy", bus.BUSY, 0);
            chk("rst go held cmd", bus.CORE_CMD_VALID, 0);
        end
        bus.CFG[0] = 1'b0;
        @(negedge PCLK);
        bus.CFG[0] = 1'b1;
        @(negedge PCLK);
        chk("rst fresh go valid", bus.CORE_CMD_VALID, 1);
        chk("rst fresh go cmd", bus.CORE_CMD, 0);
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET     = 1'b0;
        bus.CFG[0] = 1'b0;
        @(negedge PCLK);

`ifdef I2C_SEQ_TIMEOUT_EN
        // Timeout: CORE_DONE withheld after START
        bus.TIMEOUT = 14'd20;
        bus.CFG[0]  = 1'b1;
        @(negedge PCLK);
        chk("to start valid", bus.CORE_CMD_VALID, 1);
        bus.CORE_READY = 1'b1;
        @(negedge PCLK);
        bus.CORE_READY = 1'b0;
        repeat (19) @(negedge PCLK);
        chk("to not yet", bus.ERR_CODE, 0);
        @(negedge PCLK);
        chk("to err_code", bus.ERR_CODE, 3);
        chk("to stop cmd", bus.CORE_CMD, 4);
        bus.TIMEOUT = '0;
        serve("to stop", 3'd4, 1'b0, 8'h00, 1'b1, 8'h00);
        chk("to xfer_done", bus.XFER_DONE, 1);
        chk("to error", bus.ERROR, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
